// File: rtl/axis_write.sv
// axis_write: AXI4 write master. Takes a start address and word count from
// the config bus, packs a DATA_WIDTH stream into AXI_DATA_WIDTH beats through
// a beat FIFO, and issues AW bursts and W beats. B responses are not handled.
module axis_write #(
    parameter int BUF_AWIDTH     = 9,
    parameter int CONFIG_ID      = 1,
    parameter int CONFIG_ADDR    = 23,
    parameter int CONFIG_DATA    = 24,
    parameter int CONFIG_AWIDTH  = 5,
    parameter int CONFIG_DWIDTH  = 32,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CONFIG_AWIDTH-1:0]  cfg_addr,
    input  logic [CONFIG_DWIDTH-1:0]  cfg_data,
    input  logic                      cfg_valid,
    input  logic                      axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
    output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
    output logic                      axi_awvalid,
    output logic                      axi_wlast,
    output logic [AXI_DATA_WIDTH-1:0] axi_wdata,
    output logic                      axi_wvalid,
    input  logic                      axi_wready,
    input  logic [DATA_WIDTH-1:0]     data,
    input  logic                      valid,
    output logic                      ready
);
    // State table:
    //   CFG_IDLE   | waiting for the ID select write
    //   CFG_START  | waiting for the start byte address
    //   CFG_LEN    | waiting for the length in stream words
    //   CFG_ACTIVE | transfer running; config writes ignored
    localparam int CW    = CONFIG_DWIDTH;
    localparam int LANES = AXI_DATA_WIDTH / DATA_WIDTH;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int DEPTH = 1 << BUF_AWIDTH;
    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam logic [CW-1:0] MAXB = CW'(1) << AXI_LEN_WIDTH;

    typedef enum logic [1:0] {CFG_IDLE, CFG_START, CFG_LEN, CFG_ACTIVE} c_state_t;
    c_state_t c_state;

    logic [AXI_ADDR_WIDTH-1:0] r_start, r_next_addr;
    logic [CW-1:0]             r_len, r_rcvd, r_aw_rem, r_w_rem, r_w_cnt;
    logic [AXI_DATA_WIDTH-1:0] r_pack;
    logic [LW-1:0]             r_lane;
    logic [AXI_DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [BUF_AWIDTH-1:0]     r_wr_ptr, r_rd_ptr;
    logic [BUF_AWIDTH:0]       r_count;

    logic                      w_cfg_id, w_cfg_data, w_len_load, w_full, w_empty;
    logic                      w_take, w_push, w_pop;
    logic [CW-1:0]             w_beats, w_aw_burst;
    logic [AXI_DATA_WIDTH-1:0] w_beat;

    function automatic logic [CW-1:0] clamp_burst(input logic [CW-1:0] n);
        return (n > MAXB) ? MAXB : n;
    endfunction

    assign w_cfg_id   = cfg_valid && (cfg_addr == CONFIG_AWIDTH'(CONFIG_ADDR))
                        && (cfg_data == CW'(CONFIG_ID));
    assign w_cfg_data = cfg_valid && (cfg_addr == CONFIG_AWIDTH'(CONFIG_DATA));
    assign w_len_load = (c_state == CFG_LEN) && w_cfg_data;
    // Beats needed to hold the requested words, rounding a partial beat up.
    assign w_beats    = (cfg_data / CW'(LANES))
                        + {{(CW-1){1'b0}}, |(cfg_data % CW'(LANES))};
    assign w_aw_burst = clamp_burst(r_aw_rem);

    assign w_full  = (r_count == (BUF_AWIDTH+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign ready   = (c_state == CFG_ACTIVE) && (r_rcvd < r_len) && !w_full;
    assign w_take  = valid && ready;
    // A beat is pushed when its top lane fills or the final word arrives.
    assign w_push  = w_take && ((r_lane == LW'(LANES-1)) || (r_rcvd + CW'(1) == r_len));
    assign w_pop   = !w_empty && axi_wready;

    assign axi_wvalid = !w_empty;
    assign axi_wdata  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign axi_wlast  = !w_empty && (r_w_cnt == CW'(1));

    // Little-endian lane insert of the incoming word into the partial beat.
    always_comb begin
        w_beat = r_pack | (AXI_DATA_WIDTH'(data) << (r_lane * DATA_WIDTH));
    end

    // Config sequencing and transfer completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_state <= CFG_IDLE;
            r_start <= '0;
            r_len   <= '0;
        end else begin
            case (c_state)
                CFG_IDLE:   if (w_cfg_id) c_state <= CFG_START;
                CFG_START:  if (w_cfg_data) begin
                                r_start <= AXI_ADDR_WIDTH'(cfg_data);
                                c_state <= CFG_LEN;
                            end
                CFG_LEN:    if (w_cfg_data) begin
                                r_len   <= cfg_data;
                                c_state <= CFG_ACTIVE;
                            end
                CFG_ACTIVE: if (r_aw_rem == '0 && !axi_awvalid && r_w_rem == '0)
                                c_state <= CFG_IDLE;
                default:    c_state <= CFG_IDLE;
            endcase
        end
    end

    // Address channel: one burst held until accepted, next burst follows directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            axi_awvalid <= 1'b0;
            axi_awaddr  <= '0;
            axi_awlen   <= '0;
            r_aw_rem    <= '0;
            r_next_addr <= '0;
        end else if (w_len_load) begin
            r_aw_rem    <= w_beats;
            r_next_addr <= r_start;
        end else if (c_state == CFG_ACTIVE && (!axi_awvalid || axi_awready)) begin
            if (r_aw_rem != '0) begin
                axi_awvalid <= 1'b1;
                axi_awaddr  <= r_next_addr;
                axi_awlen   <= AXI_LEN_WIDTH'(w_aw_burst - CW'(1));
                r_next_addr <= r_next_addr + AXI_ADDR_WIDTH'(w_aw_burst * BYTES);
                r_aw_rem    <= r_aw_rem - w_aw_burst;
            end else begin
                axi_awvalid <= 1'b0;
            end
        end
    end

    // Stream packer: word counter, lane index and partial beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pack <= '0;
            r_lane <= '0;
            r_rcvd <= '0;
        end else if (w_len_load) begin
            r_pack <= '0;
            r_lane <= '0;
            r_rcvd <= '0;
        end else if (w_take) begin
            r_rcvd <= r_rcvd + CW'(1);
            if (w_push) begin
                r_pack <= '0;
                r_lane <= '0;
            end else begin
                r_pack <= w_beat;
                r_lane <= r_lane + LW'(1);
            end
        end
    end

    // W-side burst tracking: beats left overall and within the current burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_w_rem <= '0;
            r_w_cnt <= '0;
        end else if (w_len_load) begin
            r_w_rem <= w_beats;
            r_w_cnt <= clamp_burst(w_beats);
        end else if (w_pop) begin
            r_w_rem <= r_w_rem - CW'(1);
            r_w_cnt <= (r_w_cnt == CW'(1)) ? clamp_burst(r_w_rem - CW'(1))
                                           : r_w_cnt - CW'(1);
        end
    end

    // Beat FIFO storage; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_beat;
    end

    // Beat FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + BUF_AWIDTH'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + BUF_AWIDTH'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (BUF_AWIDTH+1)'(1);
                2'b01:   r_count <= r_count - (BUF_AWIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_write.sv
// tb_axis_write: directed transfers through axis_write with 256-bit beats,
// 4-beat maximum bursts and a 16-beat FIFO.
module tb_axis_write;
    localparam int DW = 32, ADW = 256, LANES = 8, MAXB = 4, DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   cfg_addr;
    logic [31:0]  cfg_data;
    logic         cfg_valid;
    logic         awready;
    logic [31:0]  awaddr;
    logic [1:0]   awlen;
    logic         awvalid;
    logic         wlast;
    logic [255:0] wdata;
    logic         wvalid;
    logic         wready;
    logic [31:0]  data;
    logic         valid;
    logic         ready;

    axis_write #(
        .BUF_AWIDTH(4), .AXI_LEN_WIDTH(2), .AXI_DATA_WIDTH(ADW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .axi_awready(awready), .axi_awaddr(awaddr),
        .axi_awlen(awlen), .axi_awvalid(awvalid), .axi_wlast(wlast),
        .axi_wdata(wdata), .axi_wvalid(wvalid), .axi_wready(wready),
        .data(data), .valid(valid), .ready(ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor-owned logs and counters, sampled on the falling edge.
    logic [31:0]  q_word[$];
    logic [31:0]  q_awaddr[$];
    logic [1:0]   q_awlen[$];
    logic [255:0] q_wdata[$];
    logic         q_wlast[$];
    int n_stall_rdy = 0, n_ready_hi = 0, aw_viol = 0, w_viol = 0;
    int n_wv_cycles = 0, n_wv_at_word = 0;
    logic         p_aw_stall = 1'b0, p_w_stall = 1'b0;
    logic [31:0]  p_awaddr;
    logic [1:0]   p_awlen;
    logic [255:0] p_wdata;

    always @(negedge clk) begin
        if (!rst) begin
            p_aw_stall = 1'b0;
            p_w_stall  = 1'b0;
        end else begin
            if (wvalid) n_wv_cycles++;
            if (valid && ready) begin
                q_word.push_back(data);
                n_wv_at_word = n_wv_cycles;
            end
            if (valid && !ready) n_stall_rdy++;
            if (ready) n_ready_hi++;
            if (p_aw_stall && (!awvalid || awaddr !== p_awaddr || awlen !== p_awlen)) aw_viol++;
            if (p_w_stall && (!wvalid || wdata !== p_wdata)) w_viol++;
            if (awvalid && awready) begin
                q_awaddr.push_back(awaddr);
                q_awlen.push_back(awlen);
            end
            if (wvalid && wready) begin
                q_wdata.push_back(wdata);
                q_wlast.push_back(wlast);
            end
            p_aw_stall = awvalid && !awready;
            p_w_stall  = wvalid && !wready;
            p_awaddr   = awaddr;
            p_awlen    = awlen;
            p_wdata    = wdata;
        end
    end

    // Per-run snapshots so each run looks only at its own log entries.
    int ow, oa, owd, s_stall, s_rhi, s_awv, s_wv, s_wvc;
    int held_words;
    logic held_rdy;

    task automatic snap();
        ow = q_word.size(); oa = q_awaddr.size(); owd = q_wdata.size();
        s_stall = n_stall_rdy; s_rhi = n_ready_hi; s_awv = aw_viol; s_wv = w_viol;
        s_wvc = n_wv_cycles;
    endtask

    task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
        cfg_addr = a; cfg_data = d; cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic configure(input logic [31:0] addr, input logic [31:0] len, input int gap);
        cfg_wr(5'd23, 32'd1);
        idle(gap);
        cfg_wr(5'd24, addr);
        idle(gap);
        cfg_wr(5'd24, len);
    endtask

    task automatic verify(input logic [31:0] addr, input int len, input logic [31:0] seed);
        int nb, nbu, bb;
        logic [255:0] e;
        nb  = (len + LANES - 1) / LANES;
        nbu = (nb + MAXB - 1) / MAXB;
        check("n_words", q_word.size() - ow, len);
        check("n_aw", q_awaddr.size() - oa, nbu);
        check("n_w", q_wdata.size() - owd, nb);
        check("aw_stable", aw_viol - s_awv, 0);
        check("w_stable", w_viol - s_wv, 0);
        for (int i = 0; i < nbu && oa + i < q_awaddr.size(); i++) begin
            bb = nb - MAXB * i;
            if (bb > MAXB) bb = MAXB;
            check($sformatf("awaddr[%0d]", i), q_awaddr[oa+i], addr + 32'(i * 128));
            check($sformatf("awlen[%0d]", i), q_awlen[oa+i], bb - 1);
        end
        for (int b = 0; b < nb && owd + b < q_wdata.size(); b++) begin
            e = '0;
            for (int j = 0; j < LANES; j++)
                if (b * LANES + j < len) e[j*DW +: DW] = seed + 32'(b * LANES + j);
            check($sformatf("wdata[%0d]", b), q_wdata[owd+b], e);
            check($sformatf("wlast[%0d]", b), q_wlast[owd+b],
                  ((b % MAXB) == MAXB - 1) || (b == nb - 1));
        end
    endtask

    // wr_mode: 0 wready high, 1 toggling. aw_mode: 0 awready high, 1 low every 3rd cycle.
    // hold: wready forced low for the first hold cycles. abort_at: reset at that cycle.
    task automatic run_xfer(input logic [31:0] addr, input int len, input logic [31:0] seed,
                            input int period, input int wr_mode, input int aw_mode,
                            input int gap, input int hold, input int abort_at,
                            input bit cfg_during);
        int cyc, nxt, k, nb, nbu, budget;
        snap();
        configure(addr, len, gap);
        nb = (len + LANES - 1) / LANES;
        nbu = (nb + MAXB - 1) / MAXB;
        budget = len * period + 2000;
        cyc = 0; nxt = 0;
        while (cyc < budget) begin
            k = q_word.size() - ow;
            if (k == len && q_wdata.size() - owd >= nb && q_awaddr.size() - oa >= nbu) break;
            valid   = (k < len) && (cyc >= nxt);
            data    = seed + 32'(k);
            wready  = (cyc < hold) ? 1'b0 : (wr_mode == 1) ? 1'((cyc % 2) == 0) : 1'b1;
            awready = (aw_mode == 1) ? ((cyc % 3) != 0) : 1'b1;
            cfg_valid = 1'b0;
            if (cfg_during && cyc >= 3 && cyc <= 5) begin
                cfg_valid = 1'b1;
                cfg_addr  = (cyc == 3) ? 5'd23 : 5'd24;
                cfg_data  = (cyc == 3) ? 32'd1 : (cyc == 4) ? 32'hdead_0000 : 32'd1;
            end
            if (abort_at > 0 && cyc == abort_at) begin
                #2 rst = 1'b0;
                #1;
                check("rst_awvalid", awvalid, 0);
                check("rst_wvalid", wvalid, 0);
                check("rst_ready", ready, 0);
                check("rst_wlast", wlast, 0);
                check("rst_awaddr", awaddr, 0);
                check("rst_awlen", awlen, 0);
                check("rst_wdata", wdata, 0);
                valid = 1'b0; cfg_valid = 1'b0; wready = 1'b1; awready = 1'b1;
                idle(3);
                rst = 1'b1;
                idle(1);
                return;
            end
            @(posedge clk); #1;
            if (q_word.size() - ow != k) nxt = cyc + period;
            if (hold > 0 && cyc == hold - 1) begin
                held_words = q_word.size() - ow;
                held_rdy   = ready;
            end
            cyc++;
        end
        valid = 1'b0; cfg_valid = 1'b0; wready = 1'b1; awready = 1'b1;
        idle(6);
        verify(addr, len, seed);
    endtask

    initial begin
        rst = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_valid = 1'b0;
        awready = 1'b0; wready = 1'b0; data = '0; valid = 1'b0;
        #12;
        check("reset_awvalid", awvalid, 0);
        check("reset_wvalid", wvalid, 0);
        check("reset_ready", ready, 0);
        check("reset_wlast", wlast, 0);
        check("reset_awaddr", awaddr, 0);
        check("reset_wdata", wdata, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(2);

        // Single beat, gapped config, wready toggling mid-stream.
        run_xfer(32'd4, 8, 32'd1, 1, 1, 0, 3, 0, 0, 1'b0);
        check("t1_wdata_literal", (q_wdata.size() > owd) ? q_wdata[owd] : 'x,
              256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);

        // Back-to-back config, one word every 6 cycles.
        run_xfer(32'd4, 8, 32'd1, 6, 0, 0, 0, 0, 0, 1'b0);
        check("t2_ready_when_space", n_stall_rdy - s_stall, 0);
        check("t2_no_wvalid_before_full", n_wv_at_word - s_wvc, 0);

        // wready held low: ready drops once the FIFO holds DEPTH beats.
        run_xfer(32'h1000, 160, 32'd100, 1, 0, 1, 0, 200, 0, 1'b0);
        check("t3_held_words", held_words, DEPTH * LANES);
        check("t3_ready_low_full", held_rdy, 0);

        // Zero length: no traffic, straight back to idle.
        snap();
        configure(32'h3000, 32'd0, 2);
        idle(10);
        check("t4_no_aw", q_awaddr.size() - oa, 0);
        check("t4_no_w", n_wv_cycles - s_wvc, 0);
        check("t4_no_ready", n_ready_hi - s_rhi, 0);

        // Config writes while active are ignored; partial final beat.
        run_xfer(32'h2000, 20, 32'd500, 1, 1, 1, 2, 0, 0, 1'b1);

        // Long run: 512 beats in 128 bursts.
        run_xfer(32'd255, 4092, 32'h10000, 1, 0, 1, 0, 0, 0, 1'b0);
        check("t6_awaddr1", (q_awaddr.size() > oa + 1) ? q_awaddr[oa+1] : 'x, 32'd383);
        check("t6_last_upper_zero",
              (q_wdata.size() > owd + 511) ? q_wdata[owd+511][255:128] : 'x, 0);

        // Reset mid-transfer, then a clean transfer from an empty FIFO.
        run_xfer(32'd0, 64, 32'd7, 1, 1, 1, 0, 0, 12, 1'b0);
        run_xfer(32'h40, 16, 32'd900, 1, 0, 0, 0, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
